// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider controller: FSM state encoding,
// the width of the execute-stage request bundle, and a conditional-negate helper.
package div_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Request bundle from the execute stage: signed, req, src1, src2
  localparam int unsigned ES_TO_DIV_BUS_WD = 66;

  // Two's complement negate when neg is set; used for both |x| and sign fix-up.
  // The 32-bit wrap makes |0x80000000| == 0x80000000.
  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and keep or restore.
module div_ctrl_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit so divisors >= 2^(WIDTH-1) still compare correctly
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; a non-negative difference sets the quotient bit
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle controller for a 32-bit radix-2 restoring divider (DIV/DIVU).
// Sequences 32 iterations plus sign fix-up and holds the result until acked.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero or |src1| < |src2| finishes
// straight from IDLE with done in the following cycle.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32, // only 32 is supported
  parameter int unsigned ITER_W = 5   // 2**ITER_W == WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_ack,
  input  logic             div_cancel,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem
);

  div_state_e state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_ctrl_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (prem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Operand magnitudes, only taken for signed divides
  always_comb begin
    abs1 = cond_neg(div_src1, div_signed & div_src1[WIDTH-1]);
    abs2 = cond_neg(div_src2, div_signed & div_src2[WIDTH-1]);
  end

  // Next-state and datapath update; cancel overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_req) begin
          dvd_d   = abs1;
          dvs_d   = abs2;
          prem_d  = '0;
          qsign_d = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
          rsign_d = div_signed & div_src1[WIDTH-1];
          cnt_d   = '0;
          state_d = DIV_BUSY;
`ifdef DIV_FAST_PATH_EN
          if ((div_src2 == '0) || (abs1 < abs2)) begin
            state_d = DIV_DONE;
            quot_d  = (!div_signed && (div_src2 == '0)) ? '1 : '0;
            rem_d   = div_src1;
          end
`endif
        end
      end
      DIV_BUSY: begin
        dvd_d  = {dvd_q[WIDTH-2:0], step_q};
        prem_d = step_rem;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = DIV_DONE;
          quot_d  = cond_neg({dvd_q[WIDTH-2:0], step_q}, qsign_q);
          rem_d   = cond_neg(step_rem, rsign_q);
        end
      end
      DIV_DONE: begin
        if (div_ack) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (div_cancel) state_d = DIV_IDLE;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    div_busy = (state_q != DIV_IDLE);
    div_done = (state_q == DIV_DONE);
    div_quot = quot_q;
    div_rem  = rem_q;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: the driver pushes expected results, a monitor
// pops and compares them when div_done rises and checks stability while held.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req, div_signed, div_ack, div_cancel;
  logic [31:0] div_src1, div_src2;
  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef DIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  div_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .div_req    (div_req),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_ack    (div_ack),
    .div_cancel (div_cancel),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on rising done, then hold-stability while done stays high
  logic        done_prev = 1'b0;
  logic [31:0] held_q, held_r;
  always @(negedge clk) begin
    if (div_done === 1'b1 && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quot", div_quot, e.q);
        check("rem", div_rem, e.r);
        check("latency_cycle", cyc, e.c);
      end
      held_q <= div_quot;
      held_r <= div_rem;
    end else if (div_done === 1'b1 && done_prev) begin
      check("hold_quot", div_quot, held_q);
      check("hold_rem", div_rem, held_r);
    end
    done_prev <= (div_done === 1'b1);
  end

  task automatic wait_done(output bit ok);
    int n = 0;
    while (div_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (div_done === 1'b1);
  endtask

  // Issue one divide, scramble operands while it runs, hold, then acknowledge
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int lat,
                        input int hold);
    exp_t e;
    bit   ok;
    @(negedge clk);
    div_req = 1'b1; div_signed = sg; div_src1 = a; div_src2 = b;
    e.q = eq; e.r = er; e.c = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    div_req = 1'b0; div_src1 = $urandom; div_src2 = $urandom; div_signed = ~sg;
    wait_done(ok);
    if (!ok) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
    end
    repeat (hold) @(negedge clk);
    div_ack = 1'b1;
    @(negedge clk);
    div_ack = 1'b0;
    check("ack_done_drop", {31'd0, div_done}, 32'd0);
    check("ack_busy_drop", {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; div_ack = 1'b0; div_cancel = 1'b0;
    div_src1 = '0; div_src2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    check("rst_quot", div_quot, 32'd0);
    check("rst_rem", div_rem, 32'd0);

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 5);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, FAST ? 1 : 33, 2);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 33, 0);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, FAST ? 32'd0 : 32'd1, 32'hFFFF_FFFB,
           FAST ? 1 : 33, 0);
    run_op(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, FAST ? 1 : 33, 0);

    // Cancel at counter == 10: no result may ever appear
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; div_src1 = 32'd50; div_src2 = 32'd5;
    @(negedge clk);
    div_req = 1'b0;
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    check("cancel_busy", {31'd0, div_busy}, 32'd0);
    check("cancel_done", {31'd0, div_done}, 32'd0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

    // Cancel together with a request in IDLE: request ignored
    @(negedge clk);
    div_req = 1'b1; div_cancel = 1'b1; div_src1 = 32'd8; div_src2 = 32'd2;
    @(negedge clk);
    div_req = 1'b0; div_cancel = 1'b0;
    check("cancel_req_busy", {31'd0, div_busy}, 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; div_src1 = 32'd100; div_src2 = 32'd7;
    @(negedge clk);
    div_req = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_done", {31'd0, div_done}, 32'd0);
    check("midrst_quot", div_quot, 32'd0);
    check("midrst_rem", div_rem, 32'd0);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
